fpu_issue_ctrl: RTL

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_ctrl_pkg.sv | 37 +++
 rtl/fpu_issue_ctrl_lat_lut.sv | 42 ++++
 rtl/fpu_issue_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: operation selects,
// per-operation latencies and the issue state encoding.
package fpu_issue_ctrl_pkg;

   localparam int unsigned SEL_W = 5;
   localparam int unsigned REG_W = 5;
   localparam int unsigned LAT_W = 5;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [SEL_W-1:0] {
      FPU_FADD    = 5'b00000,
      FPU_FSUB    = 5'b00001,
      FPU_FMUL    = 5'b00010,
      FPU_FDIV    = 5'b00011,
      FPU_FSQRT   = 5'b00100,
      FPU_FSGNJ   = 5'b00101,
      FPU_FMINMAX = 5'b00110,
      FPU_FCMP    = 5'b00111,
      FPU_FCVT    = 5'b01000,
      FPU_FMV     = 5'b01001
   } fpu_op_e;

   localparam logic [LAT_W-1:0] LAT_FADD   = 5'd3;
   localparam logic [LAT_W-1:0] LAT_FMUL   = 5'd4;
   localparam logic [LAT_W-1:0] LAT_FDIV   = 5'd12;
   localparam logic [LAT_W-1:0] LAT_FSQRT  = 5'd16;
   localparam logic [LAT_W-1:0] LAT_FCVT   = 5'd2;
   localparam logic [LAT_W-1:0] LAT_SIMPLE = 5'd1;
   localparam logic [LAT_W-1:0] LAT_UNDEF  = 5'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/fpu_issue_ctrl_lat_lut.sv
// Combinational lookup of execution latency and legality for an FPU select.
module fpu_lat_lut
   import fpu_issue_ctrl_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   output logic [LAT_W-1:0] lat,
   output logic             illegal
);

   always_comb begin
      lat     = LAT_UNDEF;
      illegal = 1'b1;
      case (sel)
         FPU_FADD, FPU_FSUB: begin
            lat     = LAT_FADD;
            illegal = 1'b0;
         end
         FPU_FMUL: begin
            lat     = LAT_FMUL;
            illegal = 1'b0;
         end
         FPU_FDIV: begin
            lat     = LAT_FDIV;
            illegal = 1'b0;
         end
         FPU_FSQRT: begin
            lat     = LAT_FSQRT;
            illegal = 1'b0;
         end
         FPU_FCVT: begin
            lat     = LAT_FCVT;
            illegal = 1'b0;
         end
         FPU_FSGNJ, FPU_FMINMAX, FPU_FCMP, FPU_FMV: begin
            lat     = LAT_SIMPLE;
            illegal = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: single outstanding operation, RAW stall against the
// in-flight destination, fixed-latency writeback strobe and flush handling.
module fpu_issue_ctrl
   import fpu_issue_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic [REG_W-1:0] rd_i,
   input  logic [REG_W-1:0] rs1_i,
   input  logic [REG_W-1:0] rs2_i,
   input  logic             flush_i,
   output logic             ready_o,
   output logic             stall_o,
   output logic             start_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             wb_o,
   output logic [REG_W-1:0] rd_o,
   output logic             illegal_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q;
   logic [REG_W-1:0] rd_q;
   logic             illegal_q;
   logic [LAT_W-1:0] lat;
   logic             lat_illegal;
   logic             raw;
   logic             accept;

   fpu_lat_lut u_lat_lut (
      .sel     (sel_i),
      .lat     (lat),
      .illegal (lat_illegal)
   );

   always_comb begin
      raw = valid_i && (state_q != ST_IDLE) && ((rs1_i == rd_q) || (rs2_i == rd_q));
      ready_o = (state_q != ST_EXEC) && !raw;
      stall_o = valid_i && !ready_o;
      // rst_n term keeps start/illegal quiet while reset is held
      accept    = valid_i && ready_o && !flush_i && rst_n;
      start_o   = accept;
      illegal_o = accept && lat_illegal;
      wb_o      = (state_q == ST_DONE) && !illegal_q;
      sel_o     = sel_q;
      rd_o      = rd_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = (lat > LAT_W'(1)) ? ST_EXEC : ST_DONE;
         cnt_d   = CNT_W'(lat - LAT_W'(1));
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_EXEC: begin
               if (flush_i) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sel_q     <= '0;
         rd_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            sel_q     <= sel_i;
            rd_q      <= rd_i;
            illegal_q <= lat_illegal;
         end
      end
   end

endmodule
